// File: rtl/psimd_addsub_pipe_if.sv
// psimd_addsub_pipe_if: operand/result handshake bundle
// for the packed-SIMD add/sub unit.
interface psimd_addsub_pipe_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
);
  localparam int LANES = DATA_W / LANE_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/psimd_addsub_pipe.sv
// psimd_addsub_pipe: two-stage packed-SIMD add/sub with
// per-lane saturation or wrap and sticky overflow flags.
module psimd_addsub_pipe #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  psimd_addsub_pipe_if.slave         bus,
  input  logic                       sat_clr,
  output logic [DATA_W/LANE_W-1:0]   sticky_ovf
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int M     = LANE_W - 1;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [2:0]        s1_op;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [LANES-1:0]  s2_ovf;

  logic              s2_load;
  logic              accept;
  logic              xfer;

  logic [DATA_W-1:0] res_data;
  logic [LANES-1:0]  res_ovf;

  assign s2_load = !s2_valid || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid || s2_load);
  assign accept = bus.in_valid && bus.in_ready;
  assign xfer = s2_valid && bus.out_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ovf   = s2_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    logic [LANE_W-1:0] raw;
    logic [LANE_W-1:0] sat;
    logic [LANE_W:0]   ext;
    logic              sub;
    logic              wrap;
    logic              uns;
    logic              sovf;
    logic              ovf;

    assign a    = s1_a[i*LANE_W +: LANE_W];
    assign b    = s1_b[i*LANE_W +: LANE_W];
    assign sub  = s1_op[0];
    assign wrap = s1_op[1];
    assign uns  = s1_op[2];

    assign ext = sub ? ({1'b0, a} - {1'b0, b})
                     : ({1'b0, a} + {1'b0, b});
    assign raw = ext[LANE_W-1:0];

    assign sovf = sub
      ? ((a[M] != b[M]) && (raw[M] != a[M]))
      : ((a[M] == b[M]) && (raw[M] != a[M]));

    // ext[LANE_W] is carry on add and borrow on sub
    assign ovf = uns ? ext[LANE_W] : sovf;

    assign sat = uns
      ? (sub ? {LANE_W{1'b0}} : {LANE_W{1'b1}})
      : (a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}});

    assign res_data[i*LANE_W +: LANE_W] = (ovf && !wrap) ? sat : raw;
    assign res_ovf[i] = ovf;
  end

  // operand stage: capture on acceptance, drain into S2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_load);
      if (accept) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_op <= bus.in_op;
      end
    end
  end

  // result stage: holds data stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res_data;
        s2_ovf  <= res_ovf;
      end
    end
  end

  // sticky flags: clear takes effect before a same-cycle transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= '0;
    end else if (xfer) begin
      sticky_ovf <= sat_clr ? s2_ovf : (sticky_ovf | s2_ovf);
    end else if (sat_clr) begin
      sticky_ovf <= '0;
    end
  end
endmodule

// File: tb/tb_psimd_addsub_pipe.sv
// tb_psimd_addsub_pipe: directed vectors, backpressure,
// sticky and reset sequences for psimd_addsub_pipe.
module tb_psimd_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  logic sat_clr;
  logic sat_clr8;
  logic [3:0] sticky;
  logic [1:0] sticky8;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [3:0]  o;
  } vec_t;

  vec_t tv[9];
  vec_t tv8[2];

  psimd_addsub_pipe_if #(.DATA_W(16), .LANE_W(4)) bus ();
  psimd_addsub_pipe_if #(.DATA_W(16), .LANE_W(8)) bus8 ();

  psimd_addsub_pipe #(.DATA_W(16), .LANE_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sat_clr(sat_clr), .sticky_ovf(sticky)
  );

  psimd_addsub_pipe #(.DATA_W(16), .LANE_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .sat_clr(sat_clr8), .sticky_ovf(sticky8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] beat(input int k);
    logic [15:0] v;
    v = 16'h1111 * (k + 1);
    return v;
  endfunction

  // called at posedge+1 with an empty pipe and out_ready=1
  task automatic run16(input vec_t v, input string nm);
    bus.in_valid = 1'b1;
    bus.in_a = v.a;
    bus.in_b = v.b;
    bus.in_op = v.op;
    #1 chk({nm, " rdy"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, " lat1"}, 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk({nm, " vld"}, 32'(bus.out_valid), 1);
    chk({nm, " data"}, 32'(bus.out_data), 32'(v.d));
    chk({nm, " ovf"}, 32'(bus.out_ovf), 32'(v.o));
  endtask

  task automatic run8(input vec_t v, input string nm);
    bus8.in_valid = 1'b1;
    bus8.in_a = v.a;
    bus8.in_b = v.b;
    bus8.in_op = v.op;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    chk({nm, " lat1"}, 32'(bus8.out_valid), 0);
    @(posedge clk); #1;
    chk({nm, " vld"}, 32'(bus8.out_valid), 1);
    chk({nm, " data"}, 32'(bus8.out_data), 32'(v.d));
    chk({nm, " ovf"}, 32'(bus8.out_ovf), 32'(v.o[1:0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    int got;
    logic rdy;
    logic acc_now;
    logic xf;
    logic [15:0] d;

    tv[0] = '{3'b000, 16'h7777, 16'h1111, 16'h7777, 4'b1111};
    tv[1] = '{3'b000, 16'h8421, 16'h8111, 16'h8532, 4'b1000};
    tv[2] = '{3'b010, 16'h7777, 16'h1111, 16'h8888, 4'b1111};
    tv[3] = '{3'b101, 16'h1234, 16'h2222, 16'h0012, 4'b1000};
    tv[4] = '{3'b001, 16'h8000, 16'h1000, 16'h8000, 4'b1000};
    tv[5] = '{3'b000, 16'h1234, 16'h1111, 16'h2345, 4'b0000};
    tv[6] = '{3'b110, 16'hFFFF, 16'h0001, 16'hFFF0, 4'b0001};
    tv[7] = '{3'b111, 16'h0000, 16'h1111, 16'hFFFF, 4'b1111};
    tv[8] = '{3'b011, 16'h8000, 16'h0001, 16'h800F, 4'b0000};
    tv8[0] = '{3'b000, 16'h7F80, 16'h0180, 16'h7F80, 4'b0011};
    tv8[1] = '{3'b100, 16'hF001, 16'h2002, 16'hFF03, 4'b0010};

    rst = 1'b1;
    sat_clr = 1'b0;
    sat_clr8 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_a = '0;
    bus8.in_b = '0;
    bus8.in_op = '0;
    bus8.out_ready = 1'b1;

    @(posedge clk); #1;
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    chk("rst out_ovf", 32'(bus.out_ovf), 0);
    chk("rst sticky", 32'(sticky), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("post rst in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      run16(tv[i], $sformatf("v%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      run8(tv8[i], $sformatf("w%0d", i));
    end

    // backpressure: fill both stages with out_ready low
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a = beat(acc);
      bus.in_b = '0;
      bus.in_op = 3'b010;
      #1 rdy = bus.in_ready;
      chk($sformatf("bp rdy%0d", c), 32'(rdy), (c < 2) ? 1 : 0);
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    chk("bp accepts", 32'(acc), 2);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("bp hold vld%0d", c), 32'(bus.out_valid), 1);
      chk($sformatf("bp hold data%0d", c), 32'(bus.out_data),
          32'(beat(0)));
      @(posedge clk); #1;
    end

    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus.in_valid = (acc < 4);
      bus.in_a = beat(acc);
      #1;
      acc_now = bus.in_valid && bus.in_ready;
      xf = bus.out_valid;
      d = bus.out_data;
      @(posedge clk); #1;
      if (acc_now) acc++;
      if (xf) begin
        chk($sformatf("bp order%0d", got), 32'(d), 32'(beat(got)));
        got++;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp received", 32'(got), 4);
    @(posedge clk); #1;
    chk("bp no dup", 32'(bus.out_valid), 0);

    // sticky behaviour
    do_reset();
    run16('{3'b000, 16'h7000, 16'h1000, 16'h7000, 4'b1000}, "s0");
    @(posedge clk); #1;
    chk("sticky set", 32'(sticky), 32'h8);
    run16('{3'b000, 16'h1111, 16'h1111, 16'h2222, 4'b0000}, "s1");
    @(posedge clk); #1;
    chk("sticky kept", 32'(sticky), 32'h8);
    run16('{3'b000, 16'h0070, 16'h0010, 16'h0070, 4'b0010}, "s2");
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sticky clr+xfer", 32'(sticky), 32'h2);

    // reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_op = 3'b000;
    bus.in_a = 16'h1234;
    bus.in_b = 16'h1111;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("full vld", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1 chk("rst mid in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst mid vld", 32'(bus.out_valid), 0);
    chk("rst mid sticky", 32'(sticky), 0);
    chk("rst mid data", 32'(bus.out_data), 0);
    chk("rst mid in_ready after", 32'(bus.in_ready), 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("no stale%0d", c), 32'(bus.out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
